// File: rtl/mantissa_divider.sv
// rtl/mantissa_divider.sv - restoring radix-2 divider for floating-point mantissas
//
// Computes quotient_out = floor(dividend * 2^(QUO_WIDTH-1) / divisor), one quotient
// bit per clock. The binary point of quotient_out sits after its MSB.
//
// Ports:
//   clk_in       - clock, all state changes on the rising edge
//   rst_in       - synchronous active-high reset
//   start_in     - begin a division (only looked at while idle)
//   dividend_in  - dividend mantissa, hidden bit as MSB, captured on acceptance
//   divisor_in   - divisor mantissa, hidden bit as MSB, captured on acceptance
//   quotient_out - quotient bits, held from the done pulse until the next start
//   sticky_out   - final remainder was nonzero
//   dbz_out      - captured divisor was zero
//   busy_out     - a division is in progress or its done pulse is showing
//   done_out     - one-cycle pulse, results valid

module mantissa_divider #(
    parameter int MANT_WIDTH = 11,
    parameter int QUO_WIDTH  = MANT_WIDTH + 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [MANT_WIDTH-1:0] dividend_in,
    input  logic [MANT_WIDTH-1:0] divisor_in,
    output logic [QUO_WIDTH-1:0]  quotient_out,
    output logic                  sticky_out,
    output logic                  dbz_out,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int CNT_W = $clog2(QUO_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [MANT_WIDTH:0]   rem_q, rem_d;
    logic [MANT_WIDTH-1:0] div_q, div_d;
    logic [QUO_WIDTH-1:0]  quo_q, quo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Trial subtraction one bit wider than the remainder so its MSB is the borrow.
    logic [MANT_WIDTH+1:0] trial;
    logic                  borrow;
    logic [MANT_WIDTH:0]   next_rem;

    always_comb begin
        trial  = {1'b0, rem_q} - {2'b00, div_q};
        borrow = trial[MANT_WIDTH+1];
        // Whichever value survives is below the divisor, so the doubling cannot
        // lose a bit out of the MANT_WIDTH+1 bit remainder.
        if (borrow) begin
            next_rem = {rem_q[MANT_WIDTH-1:0], 1'b0};
        end else begin
            next_rem = {trial[MANT_WIDTH-1:0], 1'b0};
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        div_d    = div_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_in) begin
                    div_d    = divisor_in;
                    rem_d    = {1'b0, dividend_in};
                    quo_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    dbz_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end

            CALC: begin
                if (div_q == '0) begin
                    // Saturate and flag instead of iterating.
                    quo_d    = '1;
                    sticky_d = 1'b0;
                    dbz_d    = 1'b1;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    quo_d = {quo_q[QUO_WIDTH-2:0], ~borrow};
                    rem_d = next_rem;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(QUO_WIDTH - 1)) begin
                        sticky_d = (next_rem != '0);
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign quotient_out = quo_q;
    assign sticky_out   = sticky_q;
    assign dbz_out      = dbz_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;

endmodule

// File: tb/tb_mantissa_divider.sv
// tb/tb_mantissa_divider.sv - self-checking bench for mantissa_divider

module tb_mantissa_divider;

    localparam int W = 11;
    localparam int Q = 13;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [Q-1:0] quotient;
    logic         sticky;
    logic         dbz;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mantissa_divider #(.MANT_WIDTH(W), .QUO_WIDTH(Q)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start),
        .dividend_in (dvd),
        .divisor_in  (dvs),
        .quotient_out(quotient),
        .sticky_out  (sticky),
        .dbz_out     (dbz),
        .busy_out    (busy),
        .done_out    (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [Q-1:0] q, output logic s, output logic z);
        longint num;
        num = longint'(a) << (Q - 1);
        if (b == '0) begin
            q = '1; s = 1'b0; z = 1'b1;
        end else begin
            q = Q'(num / longint'(b));
            s = (num % longint'(b)) != 0;
            z = 1'b0;
        end
    endtask

    // Transaction-level model: edges remaining until idle plus expected outputs.
    int           m_left = 0;
    logic [Q-1:0] m_q = '0;
    logic         m_s = 1'b0;
    logic         m_z = 1'b0;
    logic         m_done = 1'b0;
    logic [Q-1:0] r_q = '0;
    logic         r_s = 1'b0;
    logic         r_z = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_q = '0; m_s = 1'b0; m_z = 1'b0; m_done = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                ref_div(dvd, dvs, r_q, r_s, r_z);
                m_left = (dvs == '0) ? 2 : Q + 1;
                m_q = '0; m_s = 1'b0; m_z = 1'b0;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_done = 1'b1; m_q = r_q; m_s = r_s; m_z = r_z;
            end else begin
                m_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("busy", busy, m_left > 0);
            check("done", done, m_done);
            check("sticky", sticky, m_s);
            check("dbz", dbz, m_z);
            if (m_left <= 1) check("quotient", quotient, m_q);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [Q-1:0] eq, input logic es, input logic ez, input int elat);
        int n;
        @(negedge clk);
        dvd = a; dvs = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("latency", n, elat);
        check("lit_quotient", quotient, eq);
        check("lit_sticky", sticky, es);
        check("lit_dbz", dbz, ez);
        check("model_pin", {r_q, r_s, r_z}, {eq, es, ez});
        @(negedge clk);
        check("idle_after_done", {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; dvd = '0; dvs = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_outputs", {quotient, sticky, dbz, busy, done}, '0);
        @(negedge clk);
        rst = 1'b0;

        run(11'h400, 11'h400, 13'h1000, 1'b0, 1'b0, 13);
        run(11'h400, 11'h600, 13'h0AAA, 1'b1, 1'b0, 13);
        run(11'h600, 11'h400, 13'h1800, 1'b0, 1'b0, 13);
        run(11'h7FF, 11'h400, 13'h1FFC, 1'b0, 1'b0, 13);
        run(11'h500, 11'h000, 13'h1FFF, 1'b0, 1'b1, 1);
        run(11'h000, 11'h500, 13'h0000, 1'b0, 1'b0, 13);
        run(11'h7FF, 11'h7FF, 13'h1000, 1'b0, 1'b0, 13);
        run(11'h400, 11'h7FF, 13'h0801, 1'b1, 1'b0, 13);
        run(11'h7FF, 11'h401, 13'h1FF4, 1'b1, 1'b0, 13);

        // Reset during CALC iteration 5: everything clears, no done pulse follows.
        @(negedge clk);
        dvd = 11'h7FF; dvs = 11'h400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_reset", {quotient, sticky, dbz, busy, done}, '0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) n++;
        end
        check("no_done_after_reset", n, 0);
        run(11'h400, 11'h400, 13'h1000, 1'b0, 1'b0, 13);

        // Operand changes and start pulses during CALC are ignored.
        @(negedge clk);
        dvd = 11'h400; dvs = 11'h600; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dvd = 11'h7FF; dvs = 11'h400; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("busy_ignore_q", quotient, 13'h0AAA);
        check("busy_ignore_s", sticky, 1'b1);
        @(negedge clk);

        // start held high: each new run begins one edge after the DONE cycle.
        dvd = 11'h600; dvs = 11'h400; start = 1'b1;
        @(negedge clk);
        wait_done(n);
        check("held_first_q", quotient, 13'h1800);
        repeat (2) begin
            @(negedge clk);
            n = 1;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("held_period", n, Q + 2);
            check("held_q", quotient, 13'h1800);
        end
        start = 1'b0;
        repeat (16) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mantissa_divider.md
MANTISSA_DIVIDER -- requirements
Module: mantissa_divider

Interface
REQ-001 SHALL have parameter MANT_WIDTH, default 11: width of the unsigned mantissa operands, hidden bit included as MSB.
REQ-002 SHALL have parameter QUO_WIDTH, default MANT_WIDTH+2: number of quotient bits produced.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_in, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-006 SHALL have port dividend_in, input, MANT_WIDTH bits: dividend mantissa; captured on the accepting edge.
REQ-007 SHALL have port divisor_in, input, MANT_WIDTH bits: divisor mantissa; captured on the accepting edge.
REQ-008 SHALL have port quotient_out, output, QUO_WIDTH bits: floor(dividend*2^(QUO_WIDTH-1)/divisor), binary point after the MSB.
REQ-009 SHALL have port sticky_out, output, 1 bit: 1 when the final remainder is nonzero.
REQ-010 SHALL have port dbz_out, output, 1 bit: divisor was zero.
REQ-011 SHALL have port busy_out, output, 1 bit: high in CALC and DONE.
REQ-012 SHALL have port done_out, output, 1 bit: one-cycle pulse; results valid.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE, all outputs registered.
REQ-014 In IDLE, start_in=1 at edge E0 SHALL capture the operands, clear quotient/sticky/dbz, load remainder R=dividend and iteration count 0, and enter CALC.
REQ-015 In CALC, each edge SHALL form trial T=R-D at MANT_WIDTH+2 bits.
REQ-016 In CALC, when T has no borrow: quotient bit=1 and R=T<<1; otherwise quotient bit=0 and R=R<<1.
REQ-017 Quotient bits SHALL shift in MSB first.
REQ-018 The remainder register SHALL be MANT_WIDTH+1 bits; no overflow is possible because R<2D always holds.
REQ-019 After QUO_WIDTH CALC edges (edge E_QUO_WIDTH), state SHALL become DONE with done_out=1 and sticky_out=(R!=0).
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE with done_out=0.
REQ-021 Latency SHALL be QUO_WIDTH+1 edges from accepting edge to the edge ending the done pulse (done_out visible in the cycle after E_QUO_WIDTH).
REQ-022 quotient_out, sticky_out and dbz_out SHALL hold their values from DONE until the next accepted start.
REQ-023 start_in SHALL be ignored in CALC and DONE; operand changes after E0 SHALL have no effect.
REQ-024 If the captured divisor is 0: no iterations; at E1 enter DONE with quotient_out all ones, sticky_out=0, dbz_out=1.
REQ-025 A zero dividend with nonzero divisor SHALL yield quotient 0, sticky 0, dbz 0 at normal latency.
REQ-026 start_in held high continuously SHALL start a new division on the first IDLE edge after each DONE.

Reset
REQ-027 rst_in=1 at any edge, including mid-CALC or in DONE, SHALL force IDLE with quotient_out=0, sticky_out=0, dbz_out=0, busy_out=0, done_out=0, and internal remainder and count cleared.
REQ-028 rst_in SHALL take priority over start_in; no partial result or done pulse SHALL survive reset.

Verification (MANT_WIDTH=11, QUO_WIDTH=13)
REQ-029 Exact division: dividend=0x400, divisor=0x400, start pulse -> done_out after 13 edges, quotient_out=0x1000, sticky_out=0, dbz_out=0.
REQ-030 Inexact division: 0x400/0x600 -> quotient_out=0x0AAA, sticky_out=1; and 0x600/0x400 -> quotient_out=0x1800, sticky_out=0.
REQ-031 Maximum quotient: 0x7FF/0x400 -> quotient_out=0x1FFC, sticky_out=0.
REQ-032 Divide by zero: divisor=0x000 -> done_out at E1, quotient_out=0x1FFF, dbz_out=1, busy_out low the following cycle.
REQ-033 Reset mid-run: rst_in at CALC iteration 5 -> all outputs 0 on the next edge, no done_out; a subsequent 0x400/0x400 still yields 0x1000.
REQ-034 Busy handling: start_in with altered operands during CALC -> ignored; result matches the first operands; with start_in held high, back-to-back runs start one edge after each DONE.
